// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_raw,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 break_detect,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int DIV   = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(OVERSAMPLE + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LAST = OVERSAMPLE / 2 + 1;
  localparam bit MAJ        = 1'b1;
`else
  localparam int START_LAST = OVERSAMPLE / 2;
  localparam bit MAJ        = 1'b0;
`endif
  localparam int BIT_LAST = OVERSAMPLE;

  // tick_cnt is 0-based: the n-th tick of a bit window arrives while tick_cnt == n-1
  localparam logic [CNT_W-1:0] ST_DEC = CNT_W'(START_LAST - 1);
  localparam logic [CNT_W-1:0] ST_CA  = CNT_W'(START_LAST - 3);
  localparam logic [CNT_W-1:0] ST_CB  = CNT_W'(START_LAST - 2);
  localparam logic [CNT_W-1:0] BT_DEC = CNT_W'(BIT_LAST - 1);
  localparam logic [CNT_W-1:0] BT_CA  = CNT_W'(BIT_LAST - 3);
  localparam logic [CNT_W-1:0] BT_CB  = CNT_W'(BIT_LAST - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t               st, st_nxt;
  logic                 sync_q, line;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick, start_det;
  logic [CNT_W-1:0]     tick_cnt, dec_idx, cap_a, cap_b;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           maj_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q, stop_err_q, stop_one_q;
  logic                 at_dec, maj_cap, vote3, sample;
  logic                 par_exp, pe_now, fe_now, brk_now;
  logic                 load, brk_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_q <= rx_raw;
      line   <= sync_q;
    end
  end

  assign start_det = (st == S_IDLE) && !line;
  assign tick      = (div_cnt == DIV_W'(DIV - 1));

  // Free-running divider, re-phased on every start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (start_det || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    dec_idx = BT_DEC;
    cap_a   = BT_CA;
    cap_b   = BT_CB;
    if (st == S_START) begin
      dec_idx = ST_DEC;
      cap_a   = ST_CA;
      cap_b   = ST_CB;
    end
    at_dec  = tick && (tick_cnt == dec_idx);
    maj_cap = tick && ((tick_cnt == cap_a) || (tick_cnt == cap_b));
    vote3   = (maj_q[1] & maj_q[0]) | (maj_q[1] & line) | (maj_q[0] & line);
    sample  = MAJ ? vote3 : line;
    par_exp = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    pe_now  = (PARITY != 0) && (par_q != par_exp);
    fe_now  = stop_err_q | ~sample;
    brk_now = (shift_q == '0) && !par_q && !stop_one_q && !sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    load      = 1'b0;
    brk_pulse = 1'b0;
    case (st)
      S_IDLE:     if (!line) st_nxt = S_START;
      S_START:    if (at_dec) st_nxt = sample ? S_IDLE : S_DATA;
      S_DATA:     if (at_dec && (bit_cnt == BIT_W'(DATA_BITS - 1)))
                    st_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:   if (at_dec) st_nxt = S_STOP;
      S_STOP: begin
        if (at_dec && (stop_cnt == 1'(STOP_BITS - 1))) begin
          if (brk_now) begin
            st_nxt    = S_BRK_WAIT;
            brk_pulse = 1'b1;
          end else begin
            st_nxt = S_IDLE;
            load   = 1'b1;
          end
        end
      end
      S_BRK_WAIT: if (line) st_nxt = S_IDLE;
      default:    st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      maj_q      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      stop_one_q <= 1'b0;
    end else begin
      if (st == S_IDLE || st == S_BRK_WAIT || at_dec) tick_cnt <= '0;
      else if (tick)                                  tick_cnt <= tick_cnt + 1'b1;
      if (maj_cap) maj_q <= {maj_q[0], line};
      if (st != S_DATA) bit_cnt <= '0;
      else if (at_dec)  bit_cnt <= bit_cnt + 1'b1;
      if (st != S_STOP) stop_cnt <= 1'b0;
      else if (at_dec)  stop_cnt <= 1'b1;
      if (st == S_DATA && at_dec) shift_q <= {sample, shift_q[DATA_BITS-1:1]};
      // Without a parity stage par_q stays 0, which is what the break check wants
      if (st == S_START) begin
        par_q      <= 1'b0;
        stop_err_q <= 1'b0;
        stop_one_q <= 1'b0;
      end
      if (st == S_PARITY && at_dec) par_q <= sample;
      if (st == S_STOP && at_dec) begin
        stop_err_q <= stop_err_q | ~sample;
        stop_one_q <= stop_one_q | sample;
      end
    end
  end

  // Holding register: a read in the same cycle as a load makes room for the new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      break_detect <= brk_pulse;
      if (load) begin
        if (!data_valid || rd_en) begin
          data_out     <= shift_q;
          frame_error  <= fe_now;
          parity_error <= pe_now;
          data_valid   <= 1'b1;
          overrun      <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_en && data_valid) begin
        data_valid   <= 1'b0;
        frame_error  <= 1'b0;
        parity_error <= 1'b0;
        overrun      <= 1'b0;
      end
    end
  end

  assign busy  = (st != S_IDLE);
  assign state = st;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised bench for uart_rx_param: instance A uses 8N2, instance B uses 7 bits, even parity, 1 stop.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int DIV      = (CLK_FREQ + (BAUD * OS) / 2) / (BAUD * OS);
  localparam int BIT_CLK  = DIV * OS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic       rx_a = 1'b1, rd_a = 1'b0, rx_b = 1'b1, rd_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       dv_a, fe_a, pe_a, ov_a, brk_a, busy_a;
  logic       dv_b, fe_b, pe_b, ov_b, brk_b, busy_b;
  logic [2:0] state_a, state_b;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_raw(rx_a), .rd_en(rd_a), .data_out(data_a),
    .data_valid(dv_a), .frame_error(fe_a), .parity_error(pe_a), .overrun(ov_a),
    .break_detect(brk_a), .busy(busy_a), .state(state_a));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(7), .STOP_BITS(1), .PARITY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_raw(rx_b), .rd_en(rd_b), .data_out(data_b),
    .data_valid(dv_b), .frame_error(fe_b), .parity_error(pe_b), .overrun(ov_b),
    .break_detect(brk_b), .busy(busy_b), .state(state_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];

  // Reference holding-register model per instance
  logic       m_valid[2], m_fe[2], m_pe[2], m_ov[2];
  logic [8:0] m_data[2];

  int   dv_rise[2] = '{0, 0};
  int   brk_hi[2]  = '{0, 0};
  logic dv_prev[2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv_a && !dv_prev[0]) dv_rise[0] = cyc;
    if (dv_b && !dv_prev[1]) dv_rise[1] = cyc;
    dv_prev[0] = dv_a;
    dv_prev[1] = dv_b;
    if (brk_a) brk_hi[0] = brk_hi[0] + 1;
    if (brk_b) brk_hi[1] = brk_hi[1] + 1;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = 1'b0; m_fe[s] = 1'b0; m_pe[s] = 1'b0; m_ov[s] = 1'b0; m_data[s] = '0;
    end
    exp_q.delete();
  endtask

  task automatic check_hold(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_dv_a"}, 32'(dv_a), 32'(m_valid[0]));
      check({tag, "_data_a"}, 32'(data_a), 32'(m_data[0]));
      check({tag, "_fe_a"}, 32'(fe_a), 32'(m_fe[0]));
      check({tag, "_pe_a"}, 32'(pe_a), 32'(m_pe[0]));
      check({tag, "_ov_a"}, 32'(ov_a), 32'(m_ov[0]));
    end else begin
      check({tag, "_dv_b"}, 32'(dv_b), 32'(m_valid[1]));
      check({tag, "_data_b"}, 32'(data_b), 32'(m_data[1]));
      check({tag, "_fe_b"}, 32'(fe_b), 32'(m_fe[1]));
      check({tag, "_pe_b"}, 32'(pe_b), 32'(m_pe[1]));
      check({tag, "_ov_b"}, 32'(ov_b), 32'(m_ov[1]));
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) rx_a = b;
    else          rx_b = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Sends one frame and updates the reference from the frame contents alone
  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input bit use_par,
                            input logic par, input int nstop, input logic [1:0] stop_mask);
    int t0, ones, ideal, lat, nbit_tot;
    logic [8:0] dm;
    logic fe, pe, brk, was_empty;
    was_empty = !m_valid[sel];
    t0 = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, par);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_mask[i]);
    if (sel == 0) rx_a = 1'b1;
    else          rx_b = 1'b1;
    dm = '0;
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      dm[i] = d[i];
      if (d[i]) ones++;
    end
    fe = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stop_mask[i]) fe = 1'b1;
    pe  = use_par && (par != ((ones % 2) == 1));
    brk = (dm == 0) && (!use_par || !par) && fe && (nstop == 1 || stop_mask[1:0] == 2'b00);
    if (!brk) begin
      if (m_valid[sel]) m_ov[sel] = 1'b1;
      else begin
        m_valid[sel] = 1'b1; m_data[sel] = dm; m_fe[sel] = fe; m_pe[sel] = pe;
        exp_q.push_back(dm);
      end
    end
    if (was_empty && !brk) begin
      nbit_tot = 1 + nbits + (use_par ? 1 : 0) + nstop;
      ideal = nbit_tot * BIT_CLK - BIT_CLK / 2;
      lat = dv_rise[sel] - t0;
      check("load_latency_in_window", 32'(lat >= ideal - 4 && lat <= ideal + 2 * DIV + 6), 32'd1);
    end
    check_hold(sel, "frame");
  endtask

  task automatic rd_pulse(input int sel);
    if (m_valid[sel])
      check("rd_word", (sel == 0) ? 32'(data_a) : 32'(data_b), 32'(exp_q.pop_front()));
    if (sel == 0) rd_a = 1'b1;
    else          rd_b = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    rd_b = 1'b0;
    m_valid[sel] = 1'b0; m_fe[sel] = 1'b0; m_pe[sel] = 1'b0; m_ov[sel] = 1'b0;
    check_hold(sel, "after_rd");
  endtask

  logic [7:0] vals[11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'hAA, 8'h55, 8'hFF};

  initial begin
    logic [8:0] v;
    logic [1:0] sm;
    logic       p;
    model_clear();
    repeat (5) @(negedge clk);
    check_hold(0, "reset");
    check_hold(1, "reset");
    check("reset_state_a", 32'(state_a), 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_brk_a", 32'(brk_a), 32'd0);
    check("reset_state_b", 32'(state_b), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vals[i]) begin
      send_frame(0, 9'(vals[i]), 8, 1'b0, 1'b0, 2, 2'b11);
      rd_pulse(0);
    end

    repeat (6) begin
      v  = 9'($urandom_range(0, 255));
      sm = {1'b1, 1'($urandom_range(0, 1))};
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_frame(0, v, 8, 1'b0, 1'b0, 2, sm);
      rd_pulse(0);
    end

    send_frame(0, 9'h0BD, 8, 1'b0, 1'b0, 2, 2'b10);
    rd_pulse(0);

    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 2, 2'b11);
    send_frame(0, 9'h034, 8, 1'b0, 1'b0, 2, 2'b11);
    rd_pulse(0);

    rx_a = 1'b0;
    repeat (BIT_CLK / 4) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check_hold(0, "glitch");
    check("glitch_state", 32'(state_a), 32'd0);
    send_frame(0, 9'h099, 8, 1'b0, 1'b0, 2, 2'b11);
    rd_pulse(0);

    rx_a = 1'b0;
    repeat (11 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
    check("break_wait_state", 32'(state_a), 32'd5);
    check("break_wait_busy", 32'(busy_a), 32'd1);
    repeat (BIT_CLK / 2) @(negedge clk);
    check("break_still_waiting", 32'(state_a), 32'd5);
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    check("break_release_state", 32'(state_a), 32'd0);
    check("break_pulse_cycles", 32'(brk_hi[0]), 32'd1);
    check_hold(0, "break");

    send_frame(1, 9'h007, 7, 1'b1, 1'b0, 1, 2'b01);
    rd_pulse(1);
    send_frame(1, 9'h007, 7, 1'b1, 1'b1, 1, 2'b01);
    rd_pulse(1);
    repeat (4) begin
      v = 9'($urandom_range(1, 127));
      p = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_frame(1, v, 7, 1'b1, p, 1, 2'b01);
      rd_pulse(1);
    end

    send_frame(0, 9'h077, 8, 1'b0, 1'b0, 2, 2'b11);
    rx_a = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx_a = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    rx_a = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_hold(0, "mid_reset");
    check("mid_reset_state", 32'(state_a), 32'd0);
    check("mid_reset_busy", 32'(busy_a), 32'd0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("post_reset_idle", 32'(state_a), 32'd0);
    send_frame(0, 9'h056, 8, 1'b0, 1'b0, 2, 2'b11);
    rd_pulse(0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("break_total_a", 32'(brk_hi[0]), 32'd1);
    check("break_total_b", 32'(brk_hi[1]), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
